// File: rtl/multicycle_sequencer_if.sv
// Shared memory port between the sequencer and the memory.
//   mem_req   : sequencer -> memory, request pending
//   mem_we    : sequencer -> memory, write (store data phase)
//   IorD      : sequencer -> memory, 0 = PC address, 1 = ALU address
//   mem_ready : memory -> sequencer, current request completes this cycle
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic IorD;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output IorD, input mem_ready);
    modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer.sv
// Control FSM for the multicycle CPU datapath. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and arbitrates the single memory port between
// instruction fetch and data access, trapping on illegal opcodes or when a
// memory request waits too long.
//
// Ports:
//   clk, reset_n            clock (rising edge), synchronous active-low reset
//   run                     leave IDLE and start fetching
//   Op, funct, zero         decoder fields of the current IR, ALU zero flag
//   mem                     memory handshake (master side)
//   IRWr, PCWr, PCSel       IR load, PC update and PC source select
//   RegWr, RegDst, MemToReg register file write controls
//   ALUSrc, ALUCtrl         ALU operand B select and operation
//   state                   current FSM state
//   trap, trap_cause        sticky fault flag and cause (01 illegal, 10 timeout)
//   retired                 completed instruction count (wraps)
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read from PC address
// DECODE | classify Op/funct, trap if illegal
// EXEC   | ALU op, branch/jump resolution
// MEM    | data read/write at ALU address
// WB     | register file write
// TRAP   | fault, held until reset
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic [5:0]             Op,
    input  logic [5:0]             funct,
    input  logic                   zero,
    multicycle_sequencer_if.master mem,
    output logic                   IRWr,
    output logic                   PCWr,
    output logic [1:0]             PCSel,
    output logic                   RegWr,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemToReg,
    output logic                   ALUSrc,
    output logic [2:0]             ALUCtrl,
    output logic [2:0]             state,
    output logic                   trap,
    output logic [1:0]             trap_cause,
    output logic [CNT_W-1:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        K_RADD, K_RSUB, K_RSLT, K_JR, K_LW, K_SW, K_J, K_JAL,
        K_BEQ, K_BNE, K_ADDI, K_XORI
    } kind_t;

    // Counter only needs to reach MEM_TIMEOUT-1; the limit cycle itself decides.
    localparam int          TW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d, kind_dec;
    logic             legal_dec;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             timeout;

    always_comb begin
        legal_dec = 1'b1;
        kind_dec  = K_RADD;
        case (Op)
            6'h00: begin
                case (funct)
                    6'h20:   kind_dec = K_RADD;
                    6'h22:   kind_dec = K_RSUB;
                    6'h2a:   kind_dec = K_RSLT;
                    6'h08:   kind_dec = K_JR;
                    default: legal_dec = 1'b0;
                endcase
            end
            6'h23:   kind_dec = K_LW;
            6'h2b:   kind_dec = K_SW;
            6'h02:   kind_dec = K_J;
            6'h03:   kind_dec = K_JAL;
            6'h04:   kind_dec = K_BEQ;
            6'h05:   kind_dec = K_BNE;
            6'h08:   kind_dec = K_ADDI;
            6'h0e:   kind_dec = K_XORI;
            default: legal_dec = 1'b0;
        endcase
    end

    assign timeout = !mem.mem_ready && (tmo_cnt_q == LIMIT);

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        trap_d       = trap_q;
        cause_d      = cause_q;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.IorD     = 1'b0;
        IRWr         = 1'b0;
        PCWr         = 1'b0;
        PCSel        = 2'b00;
        RegWr        = 1'b0;
        RegDst       = 2'b00;
        MemToReg     = 2'b00;
        ALUSrc       = 1'b0;
        ALUCtrl      = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal_dec) begin
                    kind_d  = kind_dec;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (kind_q)
                    K_RADD: begin ALUCtrl = 3'b000; state_d = S_WB; end
                    K_RSUB: begin ALUCtrl = 3'b001; state_d = S_WB; end
                    K_RSLT: begin ALUCtrl = 3'b011; state_d = S_WB; end
                    K_ADDI: begin ALUCtrl = 3'b000; ALUSrc = 1'b1; state_d = S_WB; end
                    K_XORI: begin ALUCtrl = 3'b010; ALUSrc = 1'b1; state_d = S_WB; end
                    K_LW, K_SW: begin ALUCtrl = 3'b000; ALUSrc = 1'b1; state_d = S_MEM; end
                    K_BEQ: begin ALUCtrl = 3'b001; PCSel = 2'b01; PCWr = zero; end
                    K_BNE: begin ALUCtrl = 3'b001; PCSel = 2'b01; PCWr = !zero; end
                    K_J:   begin PCWr = 1'b1; PCSel = 2'b10; end
                    K_JAL: begin
                        PCWr     = 1'b1;
                        PCSel    = 2'b10;
                        RegWr    = 1'b1;
                        RegDst   = 2'b10;
                        MemToReg = 2'b10;
                    end
                    K_JR:  begin PCWr = 1'b1; PCSel = 2'b11; end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem.mem_req = 1'b1;
                mem.IorD    = 1'b1;
                mem.mem_we  = (kind_q == K_SW);
                if (mem.mem_ready) begin
                    state_d = (kind_q == K_LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end
            end
            S_WB: begin
                RegWr   = 1'b1;
                state_d = S_FETCH;
                case (kind_q)
                    K_LW:                   MemToReg = 2'b01;
                    K_RADD, K_RSUB, K_RSLT: RegDst   = 2'b01;
                    default:                RegDst   = 2'b00;
                endcase
            end
            S_TRAP: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Waiting cycles accumulate only while staying in a memory state;
        // any entry into FETCH/MEM restarts from zero.
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        else
            tmo_cnt_d = '0;

        retired_d = retired_q;
        if ((state_d == S_FETCH) &&
            ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)))
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_RADD;
            tmo_cnt_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            tmo_cnt_q <= tmo_cnt_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule
